// File: rtl/adv7513_i2c_slave.sv
// adv7513_i2c_slave
// I2C slave modelling the ADV7513 main register map. SCL/SDA are oversampled
// with the system clock. Write and read transactions are decoded against a
// 256-byte register file. SDA is driven open-drain through sda_oe.
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   scl_in, sda_in      raw bus pin levels (asynchronous)
//   sda_oe              1 = pull SDA low (SCL is never driven)
//   host_addr/rdata     debug read port, 1-cycle registered latency
//   wr_strobe/addr/data one-cycle pulse per byte committed by an I2C write
module adv7513_i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h39,
    parameter logic [7:0] CHIP_REV   = 8'h13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] host_addr,
    output logic [7:0] host_rdata,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] DEV_ADDR  = 4'd1;
    localparam logic [3:0] DEV_ACK   = 4'd2;
    localparam logic [3:0] REG_ADDR  = 4'd3;
    localparam logic [3:0] REG_ACK   = 4'd4;
    localparam logic [3:0] WDATA     = 4'd5;
    localparam logic [3:0] WDATA_ACK = 4'd6;
    localparam logic [3:0] RDATA     = 4'd7;
    localparam logic [3:0] RDATA_ACK = 4'd8;

    // [0],[1] synchronizer stages, [2] history for edge detection
    logic [2:0] scl_sync_q, sda_sync_q;
    logic [3:0] state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    // ACK states: 0 = waiting to drive ACK, 1 = ACK driven, leave on next fall.
    // RDATA_ACK: 1 = master ACKed, load next byte on next fall.
    logic       ack_ph_q, ack_ph_d;
    logic       sda_oe_q, sda_oe_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] host_rdata_q;
    logic [7:0] regs_q [256];
    logic       reg_we_s;

    logic scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [7:0] byte_s, rd_ptr_s;

    assign scl_s      = scl_sync_q[1];
    assign sda_s      = sda_sync_q[1];
    assign scl_rise_s = scl_s & ~scl_sync_q[2];
    assign scl_fall_s = ~scl_s & scl_sync_q[2];
    assign start_s    = scl_s & scl_sync_q[2] & ~sda_s & sda_sync_q[2];
    assign stop_s     = scl_s & scl_sync_q[2] & sda_s & ~sda_sync_q[2];
    assign byte_s     = {shift_q[6:0], sda_s};
    // Register 0x00 is hard-wired to the chip revision
    assign rd_ptr_s   = (ptr_q == 8'h00) ? CHIP_REV : regs_q[ptr_q];

    assign sda_oe     = sda_oe_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign host_rdata = host_rdata_q;

    // Pin synchronizers; reset to the idle-high bus level to avoid false edges
    always_ff @(posedge clock) begin
        if (reset) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], scl_in};
            sda_sync_q <= {sda_sync_q[1:0], sda_in};
        end
    end

    // Protocol FSM next-state logic; START/STOP take priority over SCL edges
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        ack_ph_d    = ack_ph_q;
        sda_oe_d    = sda_oe_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        reg_we_s    = 1'b0;
        if (start_s) begin
            state_d   = DEV_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            ack_ph_d  = 1'b0;
        end else if (stop_s) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            ack_ph_d = 1'b0;
        end else if (scl_rise_s) begin
            case (state_q)
                DEV_ADDR, REG_ADDR, WDATA: begin
                    shift_d   = byte_s;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        case (state_q)
                            DEV_ADDR: begin
                                if (byte_s[7:1] == SLAVE_ADDR) begin
                                    state_d = DEV_ACK;
                                    rw_d    = byte_s[0];
                                end else begin
                                    state_d = IDLE;
                                end
                            end
                            REG_ADDR: begin
                                ptr_d   = byte_s;
                                state_d = REG_ACK;
                            end
                            default: begin
                                reg_we_s    = 1'b1;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = ptr_q;
                                wr_data_d   = byte_s;
                                state_d     = WDATA_ACK;
                            end
                        endcase
                    end else begin
                        state_d = state_q;
                    end
                end
                RDATA: bit_cnt_d = bit_cnt_q + 4'd1;
                RDATA_ACK: begin
                    if (!sda_s) begin
                        ptr_d    = ptr_q + 8'd1;
                        ack_ph_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
        end else if (scl_fall_s) begin
            case (state_q)
                DEV_ACK, REG_ACK, WDATA_ACK: begin
                    if (!ack_ph_q) begin
                        sda_oe_d = 1'b1;
                        ack_ph_d = 1'b1;
                    end else begin
                        ack_ph_d  = 1'b0;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        case (state_q)
                            DEV_ACK: begin
                                if (rw_q) begin
                                    state_d  = RDATA;
                                    shift_d  = rd_ptr_s;
                                    sda_oe_d = ~rd_ptr_s[7];
                                end else begin
                                    state_d = REG_ADDR;
                                end
                            end
                            REG_ACK: state_d = WDATA;
                            default: begin
                                state_d = WDATA;
                                ptr_d   = ptr_q + 8'd1;
                            end
                        endcase
                    end
                end
                RDATA: begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        ack_ph_d = 1'b0;
                        state_d  = RDATA_ACK;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                RDATA_ACK: begin
                    if (ack_ph_q) begin
                        state_d   = RDATA;
                        shift_d   = rd_ptr_s;
                        sda_oe_d  = ~rd_ptr_s[7];
                        bit_cnt_d = 4'd0;
                        ack_ph_d  = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: state_d = state_q;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Protocol FSM and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            ptr_q       <= 8'h00;
            rw_q        <= 1'b0;
            ack_ph_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            ack_ph_q    <= ack_ph_d;
            sda_oe_q    <= sda_oe_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Register file; entry 0x00 is never written so it keeps reading CHIP_REV
    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= '{default: 8'h00};
        end else if (reg_we_s && (ptr_q != 8'h00)) begin
            regs_q[ptr_q] <= byte_s;
        end
    end

    // Debug read port; reads the pre-write value on a same-cycle write
    always_ff @(posedge clock) begin
        if (reset) begin
            host_rdata_q <= 8'h00;
        end else begin
            host_rdata_q <= (host_addr == 8'h00) ? CHIP_REV : regs_q[host_addr];
        end
    end

endmodule

// File: tb/tb_adv7513_i2c_slave.sv
// Self-checking bench for adv7513_i2c_slave. A bit-banged I2C master drives
// the bus; expected responses go into a queue and a monitor process compares
// them against observed bus responses, write strobes and host reads.
module tb_adv7513_i2c_slave;

    localparam int T = 10; // system clocks per SCL half period

    logic       clock = 1'b0;
    logic       reset;
    logic       scl_m, sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] host_addr, host_rdata;
    logic       wr_strobe;
    logic [7:0] wr_addr, wr_data;

    logic [15:0] exp_q[$];   // {tag, value}
    logic [15:0] act_q[$];
    logic [15:0] wexp_q[$];  // {addr, data}
    int n_cmp = 0;
    int n_bad = 0;
    int oe_hi_cnt = 0;
    logic end_req = 1'b0;
    logic end_ack = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clock = ~clock;

    adv7513_i2c_slave dut (
        .clock      (clock),
        .reset      (reset),
        .scl_in     (scl_m),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    always @(posedge clock) if (sda_oe) oe_hi_cnt <= oe_hi_cnt + 1;

    task automatic clks(input int n);
        repeat (n) @(posedge clock);
    endtask

    function automatic void expect_v(input logic [7:0] tag, input logic [7:0] v);
        exp_q.push_back({tag, v});
    endfunction

    function automatic void observe(input logic [7:0] tag, input logic [7:0] v);
        act_q.push_back({tag, v});
    endfunction

    task automatic send_bit(input logic b, output logic s);
        clks(2);
        sda_m = b;
        clks(T - 2);
        scl_m = 1'b1;
        clks(T / 2);
        s = sda_line;
        clks(T / 2);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        clks(T);
        scl_m = 1'b1;
        clks(T);
        sda_m = 1'b0;
        clks(T);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        clks(2);
        sda_m = 1'b0;
        clks(T);
        scl_m = 1'b1;
        clks(T);
        sda_m = 1'b1;
        clks(T);
    endtask

    // exp_ack: expected SDA level in the 9th clock (0 = slave ACK)
    task automatic wr_byte(input logic [7:0] b, input logic exp_ack);
        logic s;
        expect_v("A", {7'd0, exp_ack});
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        observe("A", {7'd0, s});
    endtask

    task automatic rd_byte(input logic [7:0] expv, input logic master_ack);
        logic s;
        logic [7:0] v;
        expect_v("R", expv);
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            v[i] = s;
        end
        observe("R", v);
        send_bit(~master_ack, s);
    endtask

    task automatic host_chk(input logic [7:0] a, input logic [7:0] expv);
        expect_v("H", expv);
        @(negedge clock);
        host_addr = a;
        @(negedge clock);
        observe("H", host_rdata);
    endtask

    // Monitor: compares write strobes and every observed response in order
    initial begin
        logic [15:0] a, e;
        forever begin
            @(negedge clock);
            if (wr_strobe) begin
                n_cmp++;
                if (wexp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL wr_strobe: got addr %02h data %02h, required no strobe", wr_addr, wr_data);
                end else begin
                    e = wexp_q.pop_front();
                    if ({wr_addr, wr_data} !== e) begin
                        n_bad++;
                        $display("FAIL wr_strobe: got addr %02h data %02h, required addr %02h data %02h",
                                 wr_addr, wr_data, e[15:8], e[7:0]);
                    end
                end
            end
            while (act_q.size() > 0) begin
                a = act_q.pop_front();
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s: got %02h, required nothing", a[15:8], a[7:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        n_bad++;
                        $display("FAIL %s: got %02h, required %s %02h", a[15:8], a[7:0], e[15:8], e[7:0]);
                    end
                end
            end
            if (end_req && !end_ack) begin
                n_cmp++;
                if (exp_q.size() != 0 || wexp_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL leftover: got %0d/%0d pending, required 0/0", exp_q.size(), wexp_q.size());
                end
                end_ack = 1'b1;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int oe0;
        reset = 1'b1;
        host_addr = 8'h00;
        scl_m = 1'b1;
        sda_m = 1'b1;
        clks(4);
        @(negedge clock);
        expect_v("Z", 8'h00); observe("Z", {7'd0, sda_oe});
        expect_v("Z", 8'h00); observe("Z", {7'd0, wr_strobe});
        expect_v("Z", 8'h00); observe("Z", wr_addr);
        expect_v("Z", 8'h00); observe("Z", wr_data);
        expect_v("Z", 8'h00); observe("Z", host_rdata);
        reset = 1'b0;
        clks(4);

        // Single write 0x41 <= 0x10
        i2c_start();
        wr_byte(8'h72, 1'b0);
        wr_byte(8'h41, 1'b0);
        wexp_q.push_back({8'h41, 8'h10});
        wr_byte(8'h10, 1'b0);
        i2c_stop();
        host_chk(8'h41, 8'h10);

        // Combined read of register 0x00 -> CHIP_REV, master NACK
        i2c_start();
        wr_byte(8'h72, 1'b0);
        wr_byte(8'h00, 1'b0);
        i2c_start();
        wr_byte(8'h73, 1'b0);
        rd_byte(8'h13, 1'b0);
        oe0 = oe_hi_cnt;
        i2c_stop();
        expect_v("O", 8'h00); observe("O", 8'(oe_hi_cnt - oe0));

        // Burst write with pointer wrap, then burst read back
        i2c_start();
        wr_byte(8'h72, 1'b0);
        wr_byte(8'hFE, 1'b0);
        wexp_q.push_back({8'hFE, 8'hAA});
        wr_byte(8'hAA, 1'b0);
        wexp_q.push_back({8'hFF, 8'hBB});
        wr_byte(8'hBB, 1'b0);
        wexp_q.push_back({8'h00, 8'hCC});
        wr_byte(8'hCC, 1'b0);
        i2c_stop();
        i2c_start();
        wr_byte(8'h72, 1'b0);
        wr_byte(8'hFE, 1'b0);
        i2c_start();
        wr_byte(8'h73, 1'b0);
        rd_byte(8'hAA, 1'b1);
        rd_byte(8'hBB, 1'b1);
        rd_byte(8'h13, 1'b0);
        i2c_stop();
        host_chk(8'hFE, 8'hAA);
        host_chk(8'hFF, 8'hBB);
        host_chk(8'h00, 8'h13);

        // Wrong device address: never ACKed, SDA never pulled
        oe0 = oe_hi_cnt;
        i2c_start();
        wr_byte(8'h70, 1'b1);
        wr_byte(8'h42, 1'b1);
        wr_byte(8'h99, 1'b1);
        i2c_stop();
        expect_v("O", 8'h00); observe("O", 8'(oe_hi_cnt - oe0));
        i2c_start();
        wr_byte(8'h72, 1'b0);
        wr_byte(8'h42, 1'b0);
        wexp_q.push_back({8'h42, 8'h55});
        wr_byte(8'h55, 1'b0);
        i2c_stop();
        host_chk(8'h42, 8'h55);

        // Reset while driving the first (zero) bit of CHIP_REV
        i2c_start();
        wr_byte(8'h72, 1'b0);
        wr_byte(8'h00, 1'b0);
        i2c_start();
        wr_byte(8'h73, 1'b0);
        clks(8);
        @(negedge clock);
        expect_v("O", 8'h01); observe("O", {7'd0, sda_oe});
        reset = 1'b1;
        @(negedge clock);
        expect_v("O", 8'h00); observe("O", {7'd0, sda_oe});
        reset = 1'b0;
        i2c_stop();
        i2c_start();
        wr_byte(8'h73, 1'b0);
        rd_byte(8'h13, 1'b0);
        i2c_stop();
        host_chk(8'h41, 8'h00);
        host_chk(8'h42, 8'h00);

        clks(4);
        end_req = 1'b1;
        for (int i = 0; i < 100 && !end_ack; i++) @(posedge clock);
        if (!end_ack) begin
            n_bad++;
            $display("FAIL monitor_drain: got no acknowledge, required acknowledge");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adv7513_i2c_slave.md
# adv7513_i2c_slave

Synthesizable I2C slave that models the ADV7513 HDMI transmitter's main register map on the shared I2C bus. It sits directly downstream of the `i2c_master` instance driven by `adv7513_init` / `adv7513_reg_read`. It replaces the behavioural mock in `cam_test` simulations and can be dropped onto hardware for loopback checks. It oversamples SCL/SDA with the system clock, decodes write and read transactions against a 256-byte register file, and drives SDA open-drain.

## Interface

Parameters:
- `SLAVE_ADDR`, 7'h39, 7-bit bus address (0x72/0x73 in 8-bit form).
- `CHIP_REV`, 8'h13, read-only value returned at register 0x00.

Ports:
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `scl_in`  in  1  raw SCL pin level (asynchronous).
- `sda_in`  in  1  raw SDA pin level (asynchronous).
- `sda_oe`  out  1  1 = pull SDA low. The top level builds the open-drain buffer. SCL is never driven (no clock stretching).
- `host_addr`  in  8  local debug read address.
- `host_rdata`  out  8  register contents at `host_addr`, registered (1-cycle latency).
- `wr_strobe`  out  1  one-cycle pulse per byte committed by an I2C write.
- `wr_addr`  out  8  register address of the committed byte, valid with `wr_strobe`.
- `wr_data`  out  8  committed byte, valid with `wr_strobe`.

## Operation

- Input conditioning:
  - `scl_in` and `sda_in` each pass through a 2-FF synchronizer plus a history FF.
  - Edges are detected from the synchronized level and its history FF.
- Bus events, decoded from synchronized signals:
  - START: SDA falling while SCL high.
  - STOP: SDA rising while SCL high.
  - Data bits are sampled on SCL rising; `sda_oe` updates only on SCL falling.
- FSM states: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- START from any state, including repeated start:
  - bit counter is cleared and the FSM goes to DEV_ADDR;
  - `sda_oe` is released immediately;
  - the register pointer is kept.
- STOP from any state: go to IDLE and release `sda_oe`.
- DEV_ADDR: shift 8 bits MSB-first.
  - If bits[7:1] == `SLAVE_ADDR`, go to DEV_ACK and drive ACK (`sda_oe`=1) for the 9th clock.
  - R/W=0 goes next to REG_ADDR; R/W=1 goes next to RDATA.
  - On mismatch, do not ACK; go to IDLE and ignore traffic until the next START.
- REG_ADDR: 8 bits load the pointer, then REG_ACK (ACK driven), then WDATA.
- WDATA: on the 8th sampled bit:
  - write the byte to `regs[pointer]` and pulse `wr_strobe` with `wr_addr`=pointer, `wr_data`=byte;
  - then WDATA_ACK (ACK driven), pointer increments, return to WDATA.
  - Writes to 0x00 are ACKed and strobed, but register 0x00 stays `CHIP_REV`.
- RDATA:
  - At the SCL falling edge that ends the ACK, load the shift register with `regs[pointer]` (0x00 → `CHIP_REV`).
  - Drive `sda_oe` = ~bit, MSB-first, changing on each SCL falling edge.
  - After 8 bits, release SDA and go to RDATA_ACK. Sample the master's ACK on the SCL rising edge.
  - ACK (SDA=0): pointer increments, next byte.
  - NACK (SDA=1): go to IDLE; SDA stays released.
- Pointer arithmetic is 8-bit and wraps 0xFF → 0x00 on both read and write.
- Register file reset values: all 0x00 except register 0x00, which reads `CHIP_REV`.

## Timing

- Reset values: `sda_oe`=0, `wr_strobe`=0, `wr_addr`=0, `wr_data`=0, `host_rdata`=0. FSM=IDLE, pointer=0, register file cleared.
- Pin-to-response latency:
  - an SCL or SDA pin edge is recognized 3 clocks later (2 sync + edge FF);
  - `sda_oe` changes in the cycle after recognition.
- Minimum bus timing: SCL high and SCL low ≥ 8 clocks each. Below this, behaviour is undefined.
- `wr_strobe` is high for exactly 1 cycle: the cycle after the 8th WDATA bit is recognized.
- `host_rdata` reflects `host_addr` one clock after sampling. If a write to the same address occurs in the same cycle, `host_rdata` returns the old value (read-before-write).
- A START/STOP recognized in the same cycle as an SCL edge takes priority over bit processing.
- Reset asserted mid-transaction:
  - forces all reset values on the next clock;
  - SDA is released even if an ACK or data bit was being driven.

## Test plan

- Write to 0x39: START, 0x72, reg 0x41, data 0x10, STOP → three ACKs; `wr_strobe` pulses once with `wr_addr`=0x41, `wr_data`=0x10; then `host_addr`=0x41 gives `host_rdata`=0x10.
- Combined read: START, 0x72, reg 0x00, repeated START, 0x73, master NACK, STOP → returns 0x13; SDA released after the NACK; FSM=IDLE.
- Burst with wrap: write 0xAA, 0xBB, 0xCC starting at reg 0xFE. Registers 0xFE, 0xFF, 0x00 are targeted (0x00 keeps 0x13). Read back from 0xFE with two ACKs and a final NACK → 0xAA, 0xBB, 0x13.
- Wrong address: START, 0x70, … → `sda_oe` stays 0 for the whole transfer; no `wr_strobe`; a following valid transaction succeeds.
- `adv7513_init` sequence via `i2c_master` against this block → every byte ACKed; `host_rdata` matches every programmed value; `adv7513_init_done` asserts.
- Reset asserted during the RDATA of 0x00 (while a 0 bit is being driven) → `sda_oe`=0 on the next clock; pointer=0; the register at 0x41 reads 0x00.
